// File: rtl/alu_rmw_queue_pkg.sv
// Shared types for the RMW queue: function codes, head-FSM states, flag bit positions.
// Purely declarative; no logic, latency or flow control lives here.
package rmw_pkg;

  typedef enum logic [2:0] {
    RMW_INC = 3'd0,
    RMW_DEC = 3'd1,
    RMW_DEP = 3'd2,
    RMW_LSR = 3'd3,
    RMW_ASL = 3'd4,
    RMW_TSB = 3'd5,
    RMW_TRB = 3'd6,
    RMW_NEG = 3'd7
  } rmw_fn_e;

  typedef enum logic [1:0] {
    HD_IDLE  = 2'd0,
    HD_LOAD  = 2'd1,
    HD_STORE = 2'd2
  } head_state_e;

  localparam int FLAG_C   = 0;
  localparam int FLAG_Z   = 1;
  localparam int FLAG_ACQ = 4;

endpackage

// File: rtl/alu_rmw_queue_if.sv
// Scheduler / memory / flag-file / LSU signals of the RMW queue.
// slave = the queue itself, master = its environment.
interface alu_rmw_queue_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int FLAG_W = 16
);
  logic              sched_valid;
  logic              sched_rdy;
  logic [2:0]        sched_fn;
  logic [DATA_W-1:0] sched_operand;
  logic              sched_wr_flags;
  logic              sched_carry_mask;
  logic [ADDR_W-1:0] agu_addr;
  logic              mem_rdy;
  logic [DATA_W-1:0] mem_data_in;
  logic [FLAG_W-1:0] rf_flags_in;
  logic              rf_flags_wr;
  logic [FLAG_W-1:0] rf_flags_out;
  logic              lsu_ack;
  logic              lsu_deny_op;
  logic [DATA_W-1:0] lsu_data;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_data_rdy;

  modport slave (
    input  sched_valid, sched_fn, sched_operand, sched_wr_flags, sched_carry_mask,
           agu_addr, mem_rdy, mem_data_in, rf_flags_in, lsu_ack,
    output sched_rdy, rf_flags_wr, rf_flags_out, lsu_deny_op, lsu_data, lsu_addr,
           lsu_data_rdy
  );

  modport master (
    output sched_valid, sched_fn, sched_operand, sched_wr_flags, sched_carry_mask,
           agu_addr, mem_rdy, mem_data_in, rf_flags_in, lsu_ack,
    input  sched_rdy, rf_flags_wr, rf_flags_out, lsu_deny_op, lsu_data, lsu_addr,
           lsu_data_rdy
  );
endinterface

// File: rtl/alu_rmw_queue_alu_core.sv
// RMW function and flag datapath; purely combinational, zero latency, no flow control.
module rmw_alu_core
  import rmw_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 16
) (
  input  rmw_fn_e           fn_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] operand_i,
  input  logic              carry_mask_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic [DATA_W-1:0] result_o,
  output logic [FLAG_W-1:0] flags_o
);

  logic cin;
  logic c;
  logic z;
  logic acq;
  logic test_z;

  assign cin    = flags_i[FLAG_C] & carry_mask_i;
  assign test_z = ((data_i & operand_i) == '0);

  always_comb begin
    result_o = data_i;
    c        = flags_i[FLAG_C];
    acq      = 1'b0;
    case (fn_i)
      RMW_INC: result_o = data_i + DATA_W'(1);
      RMW_DEC: result_o = data_i - DATA_W'(1);
      RMW_DEP: begin
        // Decrement that saturates at zero; acq reports whether a unit was taken.
        acq      = (data_i != '0);
        result_o = acq ? data_i - DATA_W'(1) : data_i;
      end
      RMW_LSR: begin
        result_o = {cin, data_i[DATA_W-1:1]};
        c        = data_i[0];
      end
      RMW_ASL: begin
        result_o = {data_i[DATA_W-2:0], cin};
        c        = data_i[DATA_W-1];
      end
      RMW_TSB: result_o = data_i | operand_i;
      RMW_TRB: result_o = data_i & ~operand_i;
      RMW_NEG: begin
        result_o = DATA_W'(0) - data_i;
        c        = (data_i != '0);
      end
      default: result_o = data_i;
    endcase
  end

  assign z = (fn_i == RMW_TSB || fn_i == RMW_TRB) ? test_z : (result_o == '0);

  always_comb begin
    flags_o           = flags_i;
    flags_o[FLAG_C]   = c;
    flags_o[FLAG_Z]   = z;
    flags_o[FLAG_ACQ] = acq;
  end

endmodule

// File: rtl/alu_rmw_queue.sv
// Read-modify-write queue: up to DEPTH ops in flight, min 2 cycles issue-to-result,
// one completion per 2 cycles; refuses requests when full or on an in-flight address hit.
module alu_rmw_queue
  import rmw_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 2,
  parameter int FLAG_W = 16
) (
  input logic           clk,
  input logic           a_rst_n,
  alu_rmw_queue_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    rmw_fn_e           fn;
    logic [DATA_W-1:0] operand;
    logic              wr_flags;
    logic              carry_mask;
  } entry_t;

  entry_t            ent_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  head_state_e       st_q, st_d;
  logic [DATA_W-1:0] data_q;

  entry_t            head;
  logic              full;
  logic              deny;
  logic              push;
  logic              pop;
  logic              store;
  logic [DATA_W-1:0] alu_res;
  logic [FLAG_W-1:0] alu_flags;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head  = ent_q[rd_ptr_q];
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign store = (st_q == HD_STORE);
  assign push  = bus.sched_valid & bus.sched_rdy;
  assign pop   = store & bus.lsu_ack;

  // The head stays valid until the edge that consumes its ack, so it blocks through that cycle.
  always_comb begin
    deny = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && ent_q[i].addr == bus.agu_addr) deny = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      HD_IDLE:  if (cnt_q != '0) st_d = HD_LOAD;
      HD_LOAD:  if (bus.mem_rdy) st_d = HD_STORE;
      HD_STORE: if (bus.lsu_ack) st_d = (cnt_d != '0) ? HD_LOAD : HD_IDLE;
      default:  st_d = HD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      st_q     <= HD_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
      data_q   <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (st_q == HD_LOAD && bus.mem_rdy) data_q <= bus.mem_data_in;
      if (push) begin
        ent_q[wr_ptr_q] <= '{addr:       bus.agu_addr,
                             fn:         rmw_fn_e'(bus.sched_fn),
                             operand:    bus.sched_operand,
                             wr_flags:   bus.sched_wr_flags,
                             carry_mask: bus.sched_carry_mask};
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= next_ptr(rd_ptr_q);
      end
    end
  end

  rmw_alu_core #(
    .DATA_W (DATA_W),
    .FLAG_W (FLAG_W)
  ) u_alu (
    .fn_i         (head.fn),
    .data_i       (data_q),
    .operand_i    (head.operand),
    .carry_mask_i (head.carry_mask),
    .flags_i      (bus.rf_flags_in),
    .result_o     (alu_res),
    .flags_o      (alu_flags)
  );

  assign bus.sched_rdy    = ~full & ~deny;
  assign bus.lsu_deny_op  = deny;
  assign bus.lsu_data_rdy = store;
  assign bus.lsu_data     = store ? alu_res : '0;
  assign bus.lsu_addr     = (cnt_q != '0) ? head.addr : '0;
  assign bus.rf_flags_out = alu_flags;
  assign bus.rf_flags_wr  = store & bus.lsu_ack & head.wr_flags;

endmodule

// File: tb/tb_alu_rmw_queue.sv
// Directed bench for alu_rmw_queue: function results/flags, queue ordering and conflict
// blocking, input-ignore rules, output stability under backpressure and mid-op reset.
module tb_alu_rmw_queue;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu_rmw_queue_if #(.DATA_W(16), .ADDR_W(16), .FLAG_W(16)) bus ();

  alu_rmw_queue #(
    .DATA_W (16),
    .ADDR_W (16),
    .DEPTH  (2),
    .FLAG_W (16)
  ) dut (
    .clk     (clk),
    .a_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are read on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic issue(input logic [15:0] addr, input logic [2:0] fn,
                       input logic [15:0] op, input logic wrf, input logic cm);
    bus.sched_valid      = 1'b1;
    bus.agu_addr         = addr;
    bus.sched_fn         = fn;
    bus.sched_operand    = op;
    bus.sched_wr_flags   = wrf;
    bus.sched_carry_mask = cm;
  endtask

  task automatic run_op(input string tag, input logic [2:0] fn, input logic [15:0] d,
                        input logic [15:0] op, input logic wrf, input logic cm,
                        input logic [15:0] flags, input logic [15:0] exp_res,
                        input logic [15:0] exp_flags);
    issue(16'h0080, fn, op, wrf, cm);
    cyc();
    bus.sched_valid = 1'b0;
    bus.agu_addr    = 16'h0000;
    cyc();
    bus.mem_rdy     = 1'b1;
    bus.mem_data_in = d;
    cyc();
    bus.mem_rdy     = 1'b0;
    bus.rf_flags_in = flags;
    #1;
    chk({tag, "_rdy"},   32'(bus.lsu_data_rdy), 32'd1);
    chk({tag, "_res"},   32'(bus.lsu_data), 32'(exp_res));
    chk({tag, "_flags"}, 32'(bus.rf_flags_out), 32'(exp_flags));
    chk({tag, "_wr_pre"}, 32'(bus.rf_flags_wr), 32'd0);
    bus.lsu_ack = 1'b1;
    #1;
    chk({tag, "_wr_ack"}, 32'(bus.rf_flags_wr), 32'(wrf));
    cyc();
    bus.lsu_ack = 1'b0;
    #1;
    chk({tag, "_done"},    32'(bus.lsu_data_rdy), 32'd0);
    chk({tag, "_wr_post"}, 32'(bus.rf_flags_wr), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n                = 1'b0;
    bus.sched_valid      = 1'b0;
    bus.sched_fn         = 3'd0;
    bus.sched_operand    = 16'h0;
    bus.sched_wr_flags   = 1'b0;
    bus.sched_carry_mask = 1'b0;
    bus.agu_addr         = 16'h0;
    bus.mem_rdy          = 1'b0;
    bus.mem_data_in      = 16'h0;
    bus.rf_flags_in      = 16'h0;
    bus.lsu_ack          = 1'b0;

    cyc();
    cyc();
    chk("rst_sched_rdy", 32'(bus.sched_rdy), 32'd1);
    chk("rst_deny",      32'(bus.lsu_deny_op), 32'd0);
    chk("rst_data_rdy",  32'(bus.lsu_data_rdy), 32'd0);
    chk("rst_flags_wr",  32'(bus.rf_flags_wr), 32'd0);
    chk("rst_lsu_data",  32'(bus.lsu_data), 32'd0);
    chk("rst_lsu_addr",  32'(bus.lsu_addr), 32'd0);
    rst_n = 1'b1;
    cyc();

    //      tag      fn    data      operand   wrf  cm    flags     result    flags_out
    run_op("inc",    3'd0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0003);
    run_op("dep0",   3'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0002);
    run_op("dep5",   3'd2, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0004, 16'h0010);
    run_op("ror",    3'd3, 16'h0002, 16'h0000, 1'b1, 1'b1, 16'hA00D, 16'h8001, 16'hA00C);
    run_op("lsr",    3'd3, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'hA00D, 16'h0001, 16'hA00C);
    run_op("asl",    3'd4, 16'h8001, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0002, 16'h0001);
    run_op("rol",    3'd4, 16'h8001, 16'h0000, 1'b1, 1'b1, 16'h0001, 16'h0003, 16'h0001);
    run_op("tsb",    3'd5, 16'h00F0, 16'h0F00, 1'b1, 1'b0, 16'h0000, 16'h0FF0, 16'h0002);
    run_op("trb",    3'd6, 16'h0FF0, 16'h00F0, 1'b1, 1'b0, 16'h0001, 16'h0F00, 16'h0001);
    run_op("neg1",   3'd7, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h0001);
    run_op("neg0",   3'd7, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0001, 16'h0000, 16'h0002);
    run_op("dec",    3'd1, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'hFFFF, 16'h0001);

    // Fill the queue, check full/conflict blocking and in-order completion.
    issue(16'h0010, 3'd0, 16'h0, 1'b0, 1'b0);
    cyc();
    issue(16'h0020, 3'd1, 16'h0, 1'b0, 1'b0);
    cyc();
    bus.sched_valid = 1'b0;
    bus.agu_addr    = 16'h0030;
    #1;
    chk("q_full_rdy", 32'(bus.sched_rdy), 32'd0);
    chk("q_nodeny",   32'(bus.lsu_deny_op), 32'd0);
    bus.sched_valid = 1'b1;
    bus.mem_rdy     = 1'b1;
    bus.mem_data_in = 16'h0100;
    cyc();
    bus.sched_valid = 1'b0;
    bus.mem_rdy     = 1'b0;
    bus.agu_addr    = 16'h0010;
    #1;
    chk("q1_rdy",     32'(bus.lsu_data_rdy), 32'd1);
    chk("q1_addr",    32'(bus.lsu_addr), 32'h10);
    chk("q1_data",    32'(bus.lsu_data), 32'h0101);
    chk("q1_deny",    32'(bus.lsu_deny_op), 32'd1);
    chk("q1_sched",   32'(bus.sched_rdy), 32'd0);
    bus.lsu_ack = 1'b1;
    #1;
    chk("q1_deny_ack", 32'(bus.lsu_deny_op), 32'd1);
    cyc();
    bus.lsu_ack = 1'b0;
    #1;
    chk("q1_deny_gone", 32'(bus.lsu_deny_op), 32'd0);
    chk("q1_sched_ok",  32'(bus.sched_rdy), 32'd1);
    chk("q2_addr_load", 32'(bus.lsu_addr), 32'h20);
    chk("q2_not_rdy",   32'(bus.lsu_data_rdy), 32'd0);
    bus.agu_addr = 16'h0020;
    #1;
    chk("q2_deny", 32'(bus.lsu_deny_op), 32'd1);
    bus.mem_rdy     = 1'b1;
    bus.mem_data_in = 16'h0005;
    cyc();
    bus.mem_rdy = 1'b0;
    #1;
    chk("q2_data", 32'(bus.lsu_data), 32'h0004);
    chk("q2_addr", 32'(bus.lsu_addr), 32'h20);
    bus.lsu_ack = 1'b1;
    cyc();
    bus.lsu_ack = 1'b0;
    #1;
    chk("q_empty_rdy",  32'(bus.lsu_data_rdy), 32'd0);
    chk("q_empty_addr", 32'(bus.lsu_addr), 32'd0);
    chk("q_empty_deny", 32'(bus.lsu_deny_op), 32'd0);
    bus.mem_rdy = 1'b1;
    cyc();
    cyc();
    bus.mem_rdy = 1'b0;
    #1;
    chk("idle_memrdy_ignored", 32'(bus.lsu_data_rdy), 32'd0);

    // Hold off the ack with mem_rdy noise: outputs must not move.
    issue(16'h0040, 3'd0, 16'h0, 1'b0, 1'b0);
    cyc();
    bus.sched_valid = 1'b0;
    cyc();
    bus.mem_rdy     = 1'b1;
    bus.mem_data_in = 16'h1234;
    cyc();
    bus.mem_data_in = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("hold_data", 32'(bus.lsu_data), 32'h1235);
      chk("hold_addr", 32'(bus.lsu_addr), 32'h40);
      cyc();
    end
    bus.mem_rdy = 1'b0;
    bus.lsu_ack = 1'b1;
    cyc();
    bus.lsu_ack = 1'b0;
    #1;
    chk("hold_done", 32'(bus.lsu_data_rdy), 32'd0);

    // Reset while a result is waiting in STORE.
    issue(16'h0050, 3'd0, 16'h0, 1'b1, 1'b0);
    cyc();
    bus.sched_valid = 1'b0;
    cyc();
    bus.mem_rdy     = 1'b1;
    bus.mem_data_in = 16'h0007;
    cyc();
    bus.mem_rdy = 1'b0;
    #1;
    chk("prerst_rdy",  32'(bus.lsu_data_rdy), 32'd1);
    chk("prerst_deny", 32'(bus.lsu_deny_op), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy",   32'(bus.lsu_data_rdy), 32'd0);
    chk("midrst_data",  32'(bus.lsu_data), 32'd0);
    chk("midrst_deny",  32'(bus.lsu_deny_op), 32'd0);
    chk("midrst_sched", 32'(bus.sched_rdy), 32'd1);
    chk("midrst_addr",  32'(bus.lsu_addr), 32'd0);
    cyc();
    rst_n       = 1'b1;
    bus.lsu_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("postrst_wr",  32'(bus.rf_flags_wr), 32'd0);
      chk("postrst_rdy", 32'(bus.lsu_data_rdy), 32'd0);
      cyc();
    end
    bus.lsu_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
